// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column-scanned key matrix with per-key debounce and a one-deep valid/ready event port
module keypad_matrix_scanner #(
  parameter int ColumnCount = 4,
  parameter int RowCount = 4,
  parameter int SettleCycles = 16,
  parameter int DebounceScans = 4,
  parameter int ValueWidth = $clog2(ColumnCount*RowCount)
) (
  input  logic Clock,
  input  logic ResetN,
  output logic [ColumnCount-1:0] ColumnPins,
  input  logic [RowCount-1:0] RowPins,
  output logic KeyValid,
  input  logic KeyReady,
  output logic [ValueWidth-1:0] KeyValue,
  output logic KeyPressed,
  output logic MultiKey,
  output logic Overflow
);
  localparam int Keys = ColumnCount*RowCount;
  localparam int KW = $clog2(Keys);
  localparam int CW = $clog2(ColumnCount);
  localparam int RW = RowCount > 1 ? $clog2(RowCount) : 1;
  localparam int SW = SettleCycles > 1 ? $clog2(SettleCycles) : 1;
  localparam logic [0:0] DRIVE = 1'b0, SAMPLE = 1'b1;
  localparam logic [3:0] DMAX = 4'(DebounceScans);
  logic [0:0] state;
  logic [SW-1:0] settle;
  logic [CW-1:0] col, col_next;
  logic [RowCount-1:0] sync1, sync2, down, disagree, qual;
  logic [Keys-1:0] stable;
  logic [3:0] dcnt [Keys];
  logic [7:0] retry [Keys];
  logic [3:0] inc [RowCount];
  logic [KW-1:0] key [RowCount];
  logic slot_free, emit;
  logic [RW-1:0] emit_row;

  assign MultiKey = $countones(stable) >= 2;

  always_comb begin
    col_next = (col == CW'(ColumnCount-1)) ? '0 : col + 1'b1;
    down = ~sync2;
    slot_free = !KeyValid || KeyReady;
    emit_row = '0;
    for (int r = 0; r < RowCount; r++) begin
      key[r] = KW'(int'(col) * RowCount + r);
      disagree[r] = down[r] != stable[key[r]];
      inc[r] = (dcnt[key[r]] == DMAX) ? DMAX : dcnt[key[r]] + 4'd1;
      qual[r] = disagree[r] && inc[r] == DMAX;
    end
    for (int r = RowCount-1; r >= 0; r--) emit_row = qual[r] ? RW'(r) : emit_row;
    emit = state == SAMPLE && slot_free && |qual;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= RowPins;
      sync2 <= sync1;
    end
  end

  // the DRIVE-state load only changes the pins on the first edge after reset
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= DRIVE;
      settle <= '0;
      col <= '0;
      ColumnPins <= '1;
    end else if (state == DRIVE) begin
      ColumnPins <= ~(ColumnCount'(1) << col);
      state <= (settle == SW'(SettleCycles-1)) ? SAMPLE : DRIVE;
      settle <= (settle == SW'(SettleCycles-1)) ? '0 : settle + 1'b1;
    end else begin
      ColumnPins <= ~(ColumnCount'(1) << col_next);
      col <= col_next;
      state <= DRIVE;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      KeyValid <= 1'b0;
      KeyValue <= '0;
      KeyPressed <= 1'b0;
      Overflow <= 1'b0;
      stable <= '0;
      for (int k = 0; k < Keys; k++) begin
        dcnt[k] <= '0;
        retry[k] <= '0;
      end
    end else begin
      if (emit) begin
        KeyValid <= 1'b1;
        KeyValue <= ValueWidth'(key[emit_row]);
        KeyPressed <= down[emit_row];
      end else if (KeyReady) KeyValid <= 1'b0;
      if (state == SAMPLE)
        for (int r = 0; r < RowCount; r++) begin
          if (!disagree[r]) begin
            dcnt[key[r]] <= '0;
            retry[key[r]] <= '0;
          end else if (qual[r] && emit && emit_row == RW'(r)) begin
            stable[key[r]] <= down[r];
            dcnt[key[r]] <= '0;
            retry[key[r]] <= '0;
          end else if (qual[r] && !slot_free && retry[key[r]] == 8'd254) begin
            stable[key[r]] <= down[r];
            dcnt[key[r]] <= '0;
            retry[key[r]] <= '0;
            Overflow <= 1'b1;
          end else begin
            dcnt[key[r]] <= inc[r];
            retry[key[r]] <= (qual[r] && !slot_free) ? retry[key[r]] + 8'd1 : 8'd0;
          end
        end
    end
  end
endmodule
